// File: rtl/mcpred_pkg.sv
// Shared constants, prediction-register layout and saturating-counter helpers
// for the multicore local branch predictor.
package mcpred_pkg;

   localparam int MCP_PC_W      = 32;
   localparam int MCP_LHT_IDX_W = 6;
   localparam int MCP_HIST_W    = 4;
   localparam int MCP_CTR_W     = 2;

   localparam logic [MCP_CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(MCP_CTR_W-1){1'b1}}};
   localparam logic [MCP_CTR_W-1:0] CTR_MAX     = {MCP_CTR_W{1'b1}};

   typedef struct packed {
      logic                     valid;
      logic                     taken;
      logic [MCP_PC_W-1:0]      target;
      logic [MCP_PC_W-1:0]      pc;
      logic [MCP_LHT_IDX_W-1:0] idx;
      logic [MCP_HIST_W-1:0]    hist;
   } pred_reg_t;

   function automatic logic [MCP_CTR_W-1:0] ctr_inc(input logic [MCP_CTR_W-1:0] c);
      return (c == CTR_MAX) ? c : c + 1'b1;
   endfunction

   function automatic logic [MCP_CTR_W-1:0] ctr_dec(input logic [MCP_CTR_W-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/mcpred_core_slice.sv
// One core's private predictor state: local-history table, direct-mapped BTB,
// the F->D prediction register and the decode-stage resolve logic.
module mcpred_core_slice
   import mcpred_pkg::*;
#(
   parameter int PC_W      = MCP_PC_W,
   parameter int LHT_IDX_W = MCP_LHT_IDX_W,
   parameter int HIST_W    = MCP_HIST_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [PC_W-1:0]   i_pc_f,
   output logic [HIST_W-1:0] o_hist_f,
   input  logic              i_ctr_msb_f,
   output logic              o_pred_taken_f,
   output logic [PC_W-1:0]   o_pred_pc_f,
   input  logic              i_stall_d,
   input  logic              i_flush_d,
   input  logic              i_branch_d,
   input  logic              i_pcsrc_d,
   input  logic [PC_W-1:0]   i_pc_branch_d,
   output logic              o_pht_we,
   output logic [HIST_W-1:0] o_pht_idx,
   output logic              o_pht_taken,
   output logic              o_clear_d,
   output logic [PC_W-1:0]   o_redirect_pc_d
);

   localparam int DEPTH = 2 ** LHT_IDX_W;
   localparam int TAG_W = PC_W - LHT_IDX_W - 2;

   logic [DEPTH-1:0][HIST_W-1:0] r_lht;
   logic [DEPTH-1:0]             r_btb_valid;
   logic [DEPTH-1:0][TAG_W-1:0]  r_btb_tag;
   logic [DEPTH-1:0][PC_W-1:0]   r_btb_target;
   pred_reg_t                    r_pred;
   logic                         r_clear;
   logic [PC_W-1:0]              r_redirect;

   logic [LHT_IDX_W-1:0] w_idx_f;
   logic [TAG_W-1:0]     w_tag_f;
   logic                 w_hit_f;
   logic [TAG_W-1:0]     w_tag_d;
   logic                 w_hit_d;
   logic                 w_resolve;
   logic                 w_actual_taken;
   logic                 w_mispredict;
   logic [PC_W-1:0]      w_redirect;

   // Fetch-side lookup; tables are read before this cycle's update lands.
   assign w_idx_f        = i_pc_f[LHT_IDX_W+1:2];
   assign w_tag_f        = i_pc_f[PC_W-1:LHT_IDX_W+2];
   assign w_hit_f        = r_btb_valid[w_idx_f] && (r_btb_tag[w_idx_f] == w_tag_f);
   assign o_hist_f       = r_lht[w_idx_f];
   assign o_pred_taken_f = w_hit_f & i_ctr_msb_f;
   assign o_pred_pc_f    = o_pred_taken_f ? r_btb_target[w_idx_f] : i_pc_f + PC_W'(4);

   assign w_resolve      = r_pred.valid & ~i_stall_d;
   assign w_actual_taken = i_branch_d & i_pcsrc_d;
   assign w_mispredict   = w_actual_taken ? (!r_pred.taken || (r_pred.target != i_pc_branch_d))
                                          : r_pred.taken;
   assign w_redirect     = w_actual_taken ? i_pc_branch_d : r_pred.pc + PC_W'(4);
   assign w_tag_d        = r_pred.pc[PC_W-1:LHT_IDX_W+2];
   assign w_hit_d        = r_btb_valid[r_pred.idx] && (r_btb_tag[r_pred.idx] == w_tag_d);

   // Counter update request, indexed by the history used at prediction time.
   assign o_pht_we    = w_resolve & i_branch_d;
   assign o_pht_idx   = r_pred.hist;
   assign o_pht_taken = i_pcsrc_d;

   assign o_clear_d       = r_clear;
   assign o_redirect_pc_d = r_redirect;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_lht        <= '0;
         r_btb_valid  <= '0;
         r_btb_tag    <= '0;
         r_btb_target <= '0;
         r_pred       <= '0;
         r_clear      <= 1'b0;
         r_redirect   <= '0;
      end else begin
         r_clear    <= w_resolve & w_mispredict;
         r_redirect <= (w_resolve & w_mispredict) ? w_redirect : '0;

         if (w_resolve && i_branch_d) begin
            r_lht[r_pred.idx] <= {r_pred.hist[HIST_W-2:0], i_pcsrc_d};
            if (i_pcsrc_d) begin
               r_btb_valid[r_pred.idx]  <= 1'b1;
               r_btb_tag[r_pred.idx]    <= w_tag_d;
               r_btb_target[r_pred.idx] <= i_pc_branch_d;
            end
         end else if (w_resolve && w_hit_d) begin
            // A non-branch aliased onto a live BTB entry: drop it so it stops redirecting.
            r_btb_valid[r_pred.idx] <= 1'b0;
         end

         if (i_flush_d) begin
            r_pred.valid <= 1'b0;
         end else if (!i_stall_d) begin
            r_pred.valid  <= 1'b1;
            r_pred.taken  <= o_pred_taken_f;
            r_pred.target <= r_btb_target[w_idx_f];
            r_pred.pc     <= i_pc_f;
            r_pred.idx    <= w_idx_f;
            r_pred.hist   <= o_hist_f;
         end
      end
   end

endmodule

// File: rtl/multicore_local_predictor.sv
// Two-level local branch predictor for NUM_CORES pipelines: per-core slices plus
// pattern history table(s), private per core or shared with lowest-core-wins writes.
module multicore_local_predictor
   import mcpred_pkg::*;
#(
   parameter int NUM_CORES  = 2,
   parameter int PC_W       = MCP_PC_W,
   parameter int LHT_IDX_W  = MCP_LHT_IDX_W,
   parameter int HIST_W     = MCP_HIST_W,
   parameter int CTR_W      = MCP_CTR_W,
   parameter int SHARED_PHT = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CORES*PC_W-1:0] pcF,
   output logic [NUM_CORES-1:0]      predTakenF,
   output logic [NUM_CORES*PC_W-1:0] predPcF,
   input  logic [NUM_CORES-1:0]      stallD,
   input  logic [NUM_CORES-1:0]      flushD,
   input  logic [NUM_CORES-1:0]      branchD,
   input  logic [NUM_CORES-1:0]      pcsrcD,
   input  logic [NUM_CORES*PC_W-1:0] pcBranchD,
   output logic [NUM_CORES-1:0]      clearD,
   output logic [NUM_CORES*PC_W-1:0] redirectPcD
);

   localparam int NUM_PHT   = (SHARED_PHT != 0) ? 1 : NUM_CORES;
   localparam int PHT_DEPTH = 2 ** HIST_W;

   // Flat storage: table t, entry e lives at bits [(t*PHT_DEPTH+e)*CTR_W +: CTR_W].
   logic [NUM_PHT*PHT_DEPTH*CTR_W-1:0] r_pht;

   logic [NUM_CORES*HIST_W-1:0] w_hist_f;
   logic [NUM_CORES-1:0]        w_ctr_msb;
   logic [NUM_CORES-1:0]        w_pht_we;
   logic [NUM_CORES*HIST_W-1:0] w_pht_idx;
   logic [NUM_CORES-1:0]        w_pht_taken;
   logic [NUM_CORES*CTR_W-1:0]  w_pht_new;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      localparam int P = (SHARED_PHT != 0) ? 0 : c;

      logic [CTR_W-1:0] w_cur;

      assign w_ctr_msb[c] =
         r_pht[(P*PHT_DEPTH + int'(w_hist_f[c*HIST_W +: HIST_W]))*CTR_W + CTR_W - 1 +: 1];
      assign w_cur =
         r_pht[(P*PHT_DEPTH + int'(w_pht_idx[c*HIST_W +: HIST_W]))*CTR_W +: CTR_W];
      assign w_pht_new[c*CTR_W +: CTR_W] = w_pht_taken[c] ? ctr_inc(w_cur) : ctr_dec(w_cur);

      mcpred_core_slice #(
         .PC_W      (PC_W),
         .LHT_IDX_W (LHT_IDX_W),
         .HIST_W    (HIST_W)
      ) u_slice (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_pc_f          (pcF[c*PC_W +: PC_W]),
         .o_hist_f        (w_hist_f[c*HIST_W +: HIST_W]),
         .i_ctr_msb_f     (w_ctr_msb[c]),
         .o_pred_taken_f  (predTakenF[c]),
         .o_pred_pc_f     (predPcF[c*PC_W +: PC_W]),
         .i_stall_d       (stallD[c]),
         .i_flush_d       (flushD[c]),
         .i_branch_d      (branchD[c]),
         .i_pcsrc_d       (pcsrcD[c]),
         .i_pc_branch_d   (pcBranchD[c*PC_W +: PC_W]),
         .o_pht_we        (w_pht_we[c]),
         .o_pht_idx       (w_pht_idx[c*HIST_W +: HIST_W]),
         .o_pht_taken     (w_pht_taken[c]),
         .o_clear_d       (clearD[c]),
         .o_redirect_pc_d (redirectPcD[c*PC_W +: PC_W])
      );
   end

   // Walking cores from highest to lowest lets the lowest-indexed writer of a
   // shared entry land last; distinct entries all update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pht <= {(NUM_PHT*PHT_DEPTH){CTR_WEAK_NT}};
      end else begin
         for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (w_pht_we[c +: 1] == 1'b1) begin
               r_pht[(((SHARED_PHT != 0) ? 0 : c)*PHT_DEPTH
                      + int'(w_pht_idx[c*HIST_W +: HIST_W]))*CTR_W +: CTR_W]
                  <= w_pht_new[c*CTR_W +: CTR_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_multicore_local_predictor.sv
// Random and directed stimulus on a private-PHT and a shared-PHT instance, checked
// against a table-level reference model through per-instance expected queues.
module tb_multicore_local_predictor;

   localparam int NC  = 2;
   localparam int PW  = 32;
   localparam int IW  = 6;
   localparam int HW  = 4;
   localparam int CW  = 2;
   localparam int DEP = 64;
   localparam int PD  = 16;
   localparam int RW  = 2 + 2*PW;
   localparam int EW  = NC*RW;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC*PW-1:0] pcF, pcBranchD;
   logic [NC-1:0]   stallD, flushD, branchD, pcsrcD;
   logic [NC-1:0]   ptk_p, ptk_s, clr_p, clr_s;
   logic [NC*PW-1:0] ppc_p, ppc_s, rpc_p, rpc_s;

   logic            n_rst;
   logic [NC*PW-1:0] n_pcF, n_pcBranchD;
   logic [NC-1:0]   n_stallD, n_flushD, n_branchD, n_pcsrcD;

   int m_pht[$];
   int m_lht[$];
   int m_bv[$];
   logic [31:0] m_btag[$];
   logic [31:0] m_btgt[$];
   int pr_v[$];
   int pr_tk[$];
   int pr_idx[$];
   int pr_hist[$];
   logic [31:0] pr_tgt[$];
   logic [31:0] pr_pc[$];
   int m_clr[$];
   logic [31:0] m_rpc[$];

   logic [EW-1:0] exp_q_p[$];
   logic [EW-1:0] exp_q_s[$];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicore_local_predictor #(
      .NUM_CORES(NC), .PC_W(PW), .LHT_IDX_W(IW), .HIST_W(HW), .CTR_W(CW), .SHARED_PHT(0)
   ) u_dut_priv (
      .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(ptk_p), .predPcF(ppc_p),
      .stallD(stallD), .flushD(flushD), .branchD(branchD), .pcsrcD(pcsrcD),
      .pcBranchD(pcBranchD), .clearD(clr_p), .redirectPcD(rpc_p)
   );

   multicore_local_predictor #(
      .NUM_CORES(NC), .PC_W(PW), .LHT_IDX_W(IW), .HIST_W(HW), .CTR_W(CW), .SHARED_PHT(1)
   ) u_dut_shr (
      .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(ptk_s), .predPcF(ppc_s),
      .stallD(stallD), .flushD(flushD), .branchD(branchD), .pcsrcD(pcsrcD),
      .pcBranchD(pcBranchD), .clearD(clr_s), .redirectPcD(rpc_s)
   );

   // ---------------- reference model ----------------
   function automatic int cix(input int cfg, input int c);
      return cfg*NC + c;
   endfunction

   function automatic int tix(input int cfg, input int c, input int idx);
      return (cfg*NC + c)*DEP + idx;
   endfunction

   // cfg 1 is the shared configuration: every core reads table 0.
   function automatic int pix(input int cfg, input int c, input int h);
      return (cfg*NC + ((cfg == 1) ? 0 : c))*PD + h;
   endfunction

   task automatic model_alloc();
      for (int i = 0; i < 2*NC*PD; i++) m_pht.push_back(0);
      for (int i = 0; i < 2*NC*DEP; i++) begin
         m_lht.push_back(0); m_bv.push_back(0); m_btag.push_back('0); m_btgt.push_back('0);
      end
      for (int i = 0; i < 2*NC; i++) begin
         pr_v.push_back(0); pr_tk.push_back(0); pr_idx.push_back(0); pr_hist.push_back(0);
         pr_tgt.push_back('0); pr_pc.push_back('0); m_clr.push_back(0); m_rpc.push_back('0);
      end
   endtask

   task automatic model_reset(input int cfg);
      for (int c = 0; c < NC; c++) begin
         for (int h = 0; h < PD; h++) m_pht[(cfg*NC + c)*PD + h] = (1 << (CW-1)) - 1;
         for (int i = 0; i < DEP; i++) begin
            m_lht[tix(cfg, c, i)] = 0;
            m_bv[tix(cfg, c, i)]  = 0;
         end
         pr_v[cix(cfg, c)]  = 0;
         m_clr[cix(cfg, c)] = 0;
         m_rpc[cix(cfg, c)] = '0;
      end
   endtask

   task automatic model_step(input int cfg, output logic [EW-1:0] rec);
      int          f_tk[$];
      int          f_idx[$];
      int          f_hist[$];
      logic [31:0] f_tgt[$];
      int          written[$];
      logic [31:0] pc, ppc, pcb;
      int idx, h, t, ci, p, v, dup, hit, tk, act, mis;
      rec = '0;
      for (int c = 0; c < NC; c++) begin
         pc  = pcF[c*PW +: PW];
         idx = int'(pc[7:2]);
         t   = tix(cfg, c, idx);
         hit = (m_bv[t] != 0 && m_btag[t] == (pc >> 8)) ? 1 : 0;
         h   = m_lht[t];
         tk  = (hit != 0 && m_pht[pix(cfg, c, h)] >= (1 << (CW-1))) ? 1 : 0;
         ppc = (tk != 0) ? m_btgt[t] : pc + 32'd4;
         rec[c*RW +: RW] = {(tk != 0), ppc, (m_clr[cix(cfg, c)] != 0), m_rpc[cix(cfg, c)]};
         f_tk.push_back(tk); f_idx.push_back(idx); f_hist.push_back(h); f_tgt.push_back(m_btgt[t]);
      end
      if (rst == 1'b0) begin
         model_reset(cfg);
         return;
      end
      // counters: first (lowest) core to touch an entry this cycle owns it
      for (int c = 0; c < NC; c++) begin
         ci = cix(cfg, c);
         if (pr_v[ci] != 0 && stallD[c +: 1] == 1'b0 && branchD[c +: 1] == 1'b1) begin
            p = pix(cfg, c, pr_hist[ci]);
            dup = 0;
            foreach (written[k]) if (written[k] == p) dup = 1;
            if (dup == 0) begin
               written.push_back(p);
               v = m_pht[p];
               if (pcsrcD[c +: 1] == 1'b1) m_pht[p] = (v == (1 << CW) - 1) ? v : v + 1;
               else                        m_pht[p] = (v == 0) ? 0 : v - 1;
            end
         end
      end
      for (int c = 0; c < NC; c++) begin
         ci = cix(cfg, c);
         pcb = pcBranchD[c*PW +: PW];
         if (pr_v[ci] != 0 && stallD[c +: 1] == 1'b0) begin
            act = (branchD[c +: 1] == 1'b1 && pcsrcD[c +: 1] == 1'b1) ? 1 : 0;
            if (act != 0) mis = (pr_tk[ci] == 0 || pr_tgt[ci] != pcb) ? 1 : 0;
            else          mis = pr_tk[ci];
            m_clr[ci] = mis;
            m_rpc[ci] = (mis == 0) ? 32'd0 : ((act != 0) ? pcb : pr_pc[ci] + 32'd4);
            t = tix(cfg, c, pr_idx[ci]);
            if (branchD[c +: 1] == 1'b1) begin
               m_lht[t] = ((pr_hist[ci] << 1) | int'(pcsrcD[c +: 1])) % PD;
               if (pcsrcD[c +: 1] == 1'b1) begin
                  m_bv[t] = 1; m_btag[t] = pr_pc[ci] >> 8; m_btgt[t] = pcb;
               end
            end else if (m_bv[t] != 0 && m_btag[t] == (pr_pc[ci] >> 8)) begin
               m_bv[t] = 0;
            end
         end else begin
            m_clr[ci] = 0;
            m_rpc[ci] = '0;
         end
         if (flushD[c +: 1] == 1'b1) begin
            pr_v[ci] = 0;
         end else if (stallD[c +: 1] == 1'b0) begin
            pr_v[ci] = 1; pr_tk[ci] = f_tk[c]; pr_tgt[ci] = f_tgt[c];
            pr_pc[ci] = pcF[c*PW +: PW]; pr_idx[ci] = f_idx[c]; pr_hist[ci] = f_hist[c];
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit chk);
      logic [EW-1:0] rec;
      @(negedge clk);
      rst = n_rst; pcF = n_pcF; pcBranchD = n_pcBranchD;
      stallD = n_stallD; flushD = n_flushD; branchD = n_branchD; pcsrcD = n_pcsrcD;
      model_step(0, rec);
      if (chk) exp_q_p.push_back(rec);
      model_step(1, rec);
      if (chk) exp_q_s.push_back(rec);
   endtask

   task automatic set_core(input int c, input logic [31:0] pc, input bit br, input bit src,
                           input logic [31:0] tgt, input bit stall, input bit flush);
      n_pcF[c*PW +: PW] = pc;
      n_pcBranchD[c*PW +: PW] = tgt;
      n_branchD[c +: 1] = br;
      n_pcsrcD[c +: 1]  = src;
      n_stallD[c +: 1]  = stall;
      n_flushD[c +: 1]  = flush;
   endtask

   function automatic logic [31:0] rand_pc();
      case ($urandom_range(0, 7))
         0: return 32'h40;
         1: return 32'h44;
         2: return 32'h80;
         3: return 32'hC0;
         4: return 32'h140;
         5: return 32'hFFFF_FFFC;
         6: return 32'h1000_0040;
         default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic check_out(input string name, input logic [EW-1:0] e,
                            input logic [NC-1:0] tk, input logic [NC*PW-1:0] ppc,
                            input logic [NC-1:0] clr, input logic [NC*PW-1:0] rpc);
      logic [RW-1:0] er;
      for (int c = 0; c < NC; c++) begin
         er = e[c*RW +: RW];
         checks++;
         if (tk[c +: 1] !== er[RW-1]) begin
            errors++;
            $display("FAIL %s core%0d predTakenF: got %b want %b @%0t", name, c, tk[c +: 1], er[RW-1], $time);
         end
         checks++;
         if (ppc[c*PW +: PW] !== er[RW-2 -: PW]) begin
            errors++;
            $display("FAIL %s core%0d predPcF: got %h want %h @%0t", name, c, ppc[c*PW +: PW], er[RW-2 -: PW], $time);
         end
         checks++;
         if (clr[c +: 1] !== er[PW]) begin
            errors++;
            $display("FAIL %s core%0d clearD: got %b want %b @%0t", name, c, clr[c +: 1], er[PW], $time);
         end
         if (er[PW] == 1'b1) begin
            checks++;
            if (rpc[c*PW +: PW] !== er[PW-1:0]) begin
               errors++;
               $display("FAIL %s core%0d redirectPcD: got %h want %h @%0t", name, c, rpc[c*PW +: PW], er[PW-1:0], $time);
            end
         end
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      if (exp_q_p.size() > 0) check_out("priv", exp_q_p.pop_front(), ptk_p, ppc_p, clr_p, rpc_p);
      if (exp_q_s.size() > 0) check_out("shared", exp_q_s.pop_front(), ptk_s, ppc_s, clr_s, rpc_s);
   end

   // ---------------- stimulus ----------------
   initial begin
      model_alloc();
      model_reset(0);
      model_reset(1);
      n_rst = 1'b0;
      for (int c = 0; c < NC; c++) set_core(c, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0);
      step(1'b1);
      n_rst = 1'b1;

      // reset state seen from fetch
      repeat (2) step(1'b1);

      // core0 branch at 0x40 keeps taking to 0x80, core1 same PC not taken
      set_core(0, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
      set_core(1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
      repeat (10) step(1'b1);

      // target moves to 0xC0
      set_core(0, 32'h40, 1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
      repeat (6) step(1'b1);

      // saturated branch turns not taken
      set_core(0, 32'h40, 1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);
      repeat (3) step(1'b1);

      // stall during resolve, release, then flush
      set_core(0, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
      repeat (3) step(1'b1);
      set_core(0, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
      step(1'b1);
      set_core(0, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
      step(1'b1);
      set_core(0, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
      repeat (2) step(1'b1);

      // randomized traffic with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         n_rst = (i == 1500 || i == 1501) ? 1'b0 : 1'b1;
         for (int c = 0; c < NC; c++) begin
            set_core(c, rand_pc(),
                     ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 50),
                     ($urandom_range(0, 3) == 3) ? {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}
                                                 : rand_pc(),
                     ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
         end
         step(1'b1);
      end

      n_rst = 1'b1;
      for (int c = 0; c < NC; c++) set_core(c, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) step(1'b1);

      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (exp_q_p.size() != 0 || exp_q_s.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d entries left want 0/0", exp_q_p.size(), exp_q_s.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
